function_chooser_arb: RTL and testbench

- Clocked, parametrised successor of the asynchronous function chooser.
- Captures rising edges on N request lines into per-channel pending flags and arbitrates among them, fixed-priority or round-robin.
- Drives one one-hot set line at a time, holds it until the selected function returns done, then pulses fin.
- Sits between request sources and a shared bank of function units; unlike its predecessor, it queues overlapping requests instead of merging them.

---
 rtl/function_chooser_arb_if.sv | 26 ++
 rtl/function_chooser_arb.sv | 112 +++++++++++
 tb/tb_function_chooser_arb.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/function_chooser_arb_if.sv
// Request/grant bundle between the function chooser arbiter and its clients.
// The arbiter uses the master modport; request sources and function units use slave.
interface function_chooser_arb_if #(
  parameter int N = 4
);
  localparam int IDXW = $clog2(N);

  logic [N-1:0]    reqs;
  logic            done;
  logic [N-1:0]    sets;
  logic [IDXW-1:0] sel;
  logic            busy;
  logic            fin;
  logic [N-1:0]    pending;
  logic [N-1:0]    drop;

  modport master (
    input  reqs, done,
    output sets, sel, busy, fin, pending, drop
  );

  modport slave (
    output reqs, done,
    input  sets, sel, busy, fin, pending, drop
  );
endinterface

// File: rtl/function_chooser_arb.sv
// Clocked function chooser: queues rising request edges per channel and grants one
// function at a time (fixed priority or round-robin) until it reports done.
module function_chooser_arb #(
  parameter int N    = 4,
  parameter int MODE = 0
) (
  input logic                    clk,
  input logic                    rst,
  function_chooser_arb_if.master bus
);
  localparam int IDXW = $clog2(N);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state;
  logic [N-1:0]    reqs_q;
  logic [N-1:0]    pending_q;
  logic [N-1:0]    drop_q;
  logic [N-1:0]    sets_q;
  logic [IDXW-1:0] sel_q;
  logic [IDXW-1:0] last_grant;
  logic            busy_q;
  logic            fin_q;

  logic [N-1:0]    rise;
  logic [N-1:0]    grant_mask;
  logic [N-1:0]    pending_nxt;
  logic [N-1:0]    drop_nxt;
  logic [IDXW-1:0] win;
  logic            found;

  // Winner search; round-robin starts one past the last grant and wraps modulo N.
  always_comb begin : search
    logic [IDXW-1:0] start;
    logic [IDXW:0]   pos;
    // NOTE: every combinational output gets a default first so no path infers a latch.
    win   = '0;
    found = 1'b0;
    start = '0;
    pos   = '0;
    if (MODE == 1 && last_grant != IDXW'(N - 1))
      start = last_grant + 1'b1;
    for (int k = 0; k < N; k++) begin
      pos = {1'b0, start} + (IDXW + 1)'(k);
      if (pos >= (IDXW + 1)'(N))
        pos = pos - (IDXW + 1)'(N);
      if (!found && pending_q[pos[IDXW-1:0]]) begin
        win   = pos[IDXW-1:0];
        found = 1'b1;
      end
    end
  end

  // A fresh edge on the channel being granted re-queues it without a drop.
  always_comb begin
    rise       = bus.reqs & ~reqs_q;
    grant_mask = '0;
    if (state == IDLE && found)
      grant_mask[win] = 1'b1;
    pending_nxt = (pending_q & ~grant_mask) | rise;
    drop_nxt    = rise & pending_q & ~grant_mask;
  end

  // NOTE: state registers use non-blocking assignments so all of them update together.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: there is no storage array here, so every register is cleared by reset.
      state      <= IDLE;
      reqs_q     <= '0;
      pending_q  <= '0;
      drop_q     <= '0;
      sets_q     <= '0;
      sel_q      <= '0;
      last_grant <= IDXW'(N - 1);
      busy_q     <= 1'b0;
      fin_q      <= 1'b0;
    end else begin
      reqs_q    <= bus.reqs;
      pending_q <= pending_nxt;
      drop_q    <= drop_nxt;
      fin_q     <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            sets_q     <= grant_mask;
            sel_q      <= win;
            last_grant <= win;
            busy_q     <= 1'b1;
            state      <= GRANT;
          end
        end
        GRANT: begin
          if (bus.done) begin
            sets_q <= '0;
            busy_q <= 1'b0;
            fin_q  <= 1'b1;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sets    = sets_q;
  assign bus.sel     = sel_q;
  assign bus.busy    = busy_q;
  assign bus.fin     = fin_q;
  assign bus.pending = pending_q;
  assign bus.drop    = drop_q;

endmodule

// File: tb/tb_function_chooser_arb.sv
// Bench for function_chooser_arb: a fixed-priority and a round-robin instance share
// stimulus; a per-channel behavioural model predicts both every cycle.
module tb_function_chooser_arb;
  localparam int N    = 4;
  localparam int IDXW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  function_chooser_arb_if #(.N(N)) bus_fp ();
  function_chooser_arb_if #(.N(N)) bus_rr ();

  function_chooser_arb #(.N(N), .MODE(0)) u_fp (.clk(clk), .rst(rst), .bus(bus_fp));
  function_chooser_arb #(.N(N), .MODE(1)) u_rr (.clk(clk), .rst(rst), .bus(bus_rr));

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: index 0 = fixed priority, 1 = round-robin; cur = granted channel or -1.
  bit m_pend [2][N];
  bit m_drop [2][N];
  bit m_prev [N];
  int m_cur  [2] = '{-1, -1};
  int m_last [2] = '{N - 1, N - 1};
  int m_sel  [2] = '{0, 0};
  bit m_fin  [2];

  task automatic model_edge(input logic [N-1:0] r, input logic d0, input logic d1, input logic rs);
    for (int m = 0; m < 2; m++) begin
      if (rs) begin
        m_cur[m] = -1; m_last[m] = N - 1; m_sel[m] = 0; m_fin[m] = 0;
        for (int i = 0; i < N; i++) begin m_pend[m][i] = 0; m_drop[m][i] = 0; end
      end else begin
        int w;
        int start;
        bit d;
        w = -1;
        start = (m == 1) ? (m_last[m] + 1) % N : 0;
        if (m_cur[m] < 0)
          for (int k = 0; k < N; k++)
            if (w < 0 && m_pend[m][(start + k) % N]) w = (start + k) % N;
        for (int i = 0; i < N; i++) begin
          bit rise;
          rise = r[i] && !m_prev[i];
          m_drop[m][i] = rise && m_pend[m][i] && (i != w);
          m_pend[m][i] = (m_pend[m][i] && (i != w)) || rise;
        end
        d = (m == 0) ? d0 : d1;
        m_fin[m] = 0;
        if (m_cur[m] >= 0) begin
          if (d) begin m_fin[m] = 1; m_cur[m] = -1; end
        end else if (w >= 0) begin
          m_cur[m] = w; m_sel[m] = w; m_last[m] = w;
        end
      end
    end
    for (int i = 0; i < N; i++) m_prev[i] = rs ? 1'b0 : r[i];
  endtask

  function automatic logic [15:0] exp_vec(input int m);
    logic [N-1:0] s, p, dr;
    s = '0;
    if (m_cur[m] >= 0) s[m_cur[m]] = 1'b1;
    for (int i = 0; i < N; i++) begin p[i] = m_pend[m][i]; dr[i] = m_drop[m][i]; end
    return {s, IDXW'(m_sel[m]), m_cur[m] >= 0, m_fin[m], p, dr};
  endfunction

  function automatic logic [15:0] act_vec(input int m);
    if (m == 0)
      return {bus_fp.sets, bus_fp.sel, bus_fp.busy, bus_fp.fin, bus_fp.pending, bus_fp.drop};
    return {bus_rr.sets, bus_rr.sel, bus_rr.busy, bus_rr.fin, bus_rr.pending, bus_rr.drop};
  endfunction

  task automatic step(input logic [N-1:0] r, input logic d0, input logic d1, input logic rs,
                      input string tag);
    bus_fp.reqs = r; bus_rr.reqs = r;
    bus_fp.done = d0; bus_rr.done = d1;
    rst = rs;
    @(posedge clk);
    model_edge(r, d0, d1, rs);
    #1;
    check({tag, "/fp"}, act_vec(0), exp_vec(0));
    check({tag, "/rr"}, act_vec(1), exp_vec(1));
  endtask

  typedef struct {
    logic [N-1:0]    reqs;
    logic            done;
    logic            rs;
    logic [N-1:0]    sets;
    logic [IDXW-1:0] sel;
    logic            busy;
    logic            fin;
    logic [N-1:0]    pend;
    logic [N-1:0]    drop;
  } vec_t;

  function automatic vec_t v(input logic [3:0] r, input logic d, input logic rs,
                             input logic [3:0] s, input logic [1:0] sl, input logic b,
                             input logic f, input logic [3:0] p, input logic [3:0] dr);
    vec_t t;
    t.reqs = r; t.done = d; t.rs = rs; t.sets = s; t.sel = sl;
    t.busy = b; t.fin = f; t.pend = p; t.drop = dr;
    return t;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[$];
    int   order[$];
    int   exp_order[5] = '{0, 1, 2, 3, 0};
    logic [N-1:0] r;

    // Expected outputs of the fixed-priority instance after each edge.
    //                reqs    d  rst  sets    sel b  f  pend     drop
    tbl.push_back(v(4'b1111, 0, 1, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000)); // reset
    tbl.push_back(v(4'b1111, 0, 1, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b1111, 0, 1, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b1111, 0, 0, 4'b0000, 0, 0, 0, 4'b1111, 4'b0000)); // held reqs count as rises
    tbl.push_back(v(4'b1111, 0, 0, 4'b0001, 0, 1, 0, 4'b1110, 4'b0000));
    tbl.push_back(v(4'b1111, 1, 0, 4'b0000, 0, 0, 1, 4'b1110, 4'b0000));
    tbl.push_back(v(4'b1111, 0, 0, 4'b0010, 1, 1, 0, 4'b1100, 4'b0000));
    tbl.push_back(v(4'b1111, 1, 0, 4'b0000, 1, 0, 1, 4'b1100, 4'b0000));
    tbl.push_back(v(4'b0000, 0, 0, 4'b0100, 2, 1, 0, 4'b1000, 4'b0000));
    tbl.push_back(v(4'b0000, 1, 0, 4'b0000, 2, 0, 1, 4'b1000, 4'b0000));
    tbl.push_back(v(4'b0000, 0, 0, 4'b1000, 3, 1, 0, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b0000, 1, 0, 4'b0000, 3, 0, 1, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b0000, 0, 0, 4'b0000, 3, 0, 0, 4'b0000, 4'b0000)); // idle holds sel
    tbl.push_back(v(4'b1010, 0, 0, 4'b0000, 3, 0, 0, 4'b1010, 4'b0000)); // fixed priority 1010
    tbl.push_back(v(4'b1010, 0, 0, 4'b0010, 1, 1, 0, 4'b1000, 4'b0000));
    tbl.push_back(v(4'b1010, 0, 0, 4'b0010, 1, 1, 0, 4'b1000, 4'b0000));
    tbl.push_back(v(4'b1010, 1, 0, 4'b0000, 1, 0, 1, 4'b1000, 4'b0000));
    tbl.push_back(v(4'b1010, 0, 0, 4'b1000, 3, 1, 0, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b1010, 0, 0, 4'b1000, 3, 1, 0, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b1010, 1, 0, 4'b0000, 3, 0, 1, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b0000, 0, 0, 4'b0000, 3, 0, 0, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b0001, 0, 0, 4'b0000, 3, 0, 0, 4'b0001, 4'b0000)); // drop on ch2
    tbl.push_back(v(4'b0100, 0, 0, 4'b0001, 0, 1, 0, 4'b0100, 4'b0000));
    tbl.push_back(v(4'b0000, 0, 0, 4'b0001, 0, 1, 0, 4'b0100, 4'b0000));
    tbl.push_back(v(4'b0100, 0, 0, 4'b0001, 0, 1, 0, 4'b0100, 4'b0100));
    tbl.push_back(v(4'b0000, 1, 0, 4'b0000, 0, 0, 1, 4'b0100, 4'b0000));
    tbl.push_back(v(4'b0000, 0, 0, 4'b0100, 2, 1, 0, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b0100, 0, 0, 4'b0100, 2, 1, 0, 4'b0100, 4'b0000)); // re-rise in own grant
    tbl.push_back(v(4'b0000, 1, 0, 4'b0000, 2, 0, 1, 4'b0100, 4'b0000));
    tbl.push_back(v(4'b0000, 0, 0, 4'b0100, 2, 1, 0, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b0000, 1, 0, 4'b0000, 2, 0, 1, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b0000, 0, 0, 4'b0000, 2, 0, 0, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b0010, 0, 0, 4'b0000, 2, 0, 0, 4'b0010, 4'b0000)); // set-wins collision
    tbl.push_back(v(4'b0001, 0, 0, 4'b0010, 1, 1, 0, 4'b0001, 4'b0000));
    tbl.push_back(v(4'b0000, 1, 0, 4'b0000, 1, 0, 1, 4'b0001, 4'b0000));
    tbl.push_back(v(4'b0001, 0, 0, 4'b0001, 0, 1, 0, 4'b0001, 4'b0000));
    tbl.push_back(v(4'b0000, 1, 0, 4'b0000, 0, 0, 1, 4'b0001, 4'b0000));
    tbl.push_back(v(4'b0000, 0, 0, 4'b0001, 0, 1, 0, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b0000, 1, 0, 4'b0000, 0, 0, 1, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b0100, 0, 0, 4'b0000, 0, 0, 0, 4'b0100, 4'b0000)); // reset mid-grant
    tbl.push_back(v(4'b0101, 0, 0, 4'b0100, 2, 1, 0, 4'b0001, 4'b0000));
    tbl.push_back(v(4'b0101, 0, 1, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000));
    tbl.push_back(v(4'b0000, 0, 0, 4'b0000, 0, 0, 0, 4'b0000, 4'b0000));

    foreach (tbl[i]) begin
      step(tbl[i].reqs, tbl[i].done, tbl[i].done, tbl[i].rs, $sformatf("vec%0d", i));
      check($sformatf("tbl%0d", i), act_vec(0),
            {tbl[i].sets, tbl[i].sel, tbl[i].busy, tbl[i].fin, tbl[i].pend, tbl[i].drop});
    end

    // Round-robin: every channel re-requested after each completion.
    step(4'b0000, 0, 0, 1, "rr_rst");
    for (int g = 0; g < 5; g++) begin
      int waited;
      waited = 0;
      step(4'b0000, 0, 0, 0, "rr_low");
      step(4'b1111, 0, 0, 0, "rr_req");
      while (!bus_rr.busy && waited < 8) begin
        step(4'b1111, 0, 0, 0, "rr_wait");
        waited++;
      end
      check($sformatf("rr_busy%0d", g), bus_rr.busy, 1);
      order.push_back(int'(bus_rr.sel));
      step(4'b1111, 0, 1, 0, "rr_done");
    end
    foreach (exp_order[g]) check($sformatf("rr_order%0d", g), order[g], exp_order[g]);

    // done held high: each grant completes one cycle after it is issued.
    step(4'b0000, 0, 0, 1, "hold_rst");
    step(4'b1111, 1, 1, 0, "hold_req");
    for (int c = 0; c < 10; c++) step(4'b1111, 1, 1, 0, "hold");

    // Randomised run against the model, with occasional resets.
    r = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 2) == 0) r = N'($urandom);
      step(r, 1'($urandom), 1'($urandom), $urandom_range(0, 99) == 0, $sformatf("rnd%0d", c));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
